igcn_island_scheduler: RTL and testbench

Responder side of the island submission handshake used by the IGCN accelerator model. Captures one island request at a time from the host/testbench driver, allocates one or two processing elements (PEs) depending on strategy, and holds each allocated PE for a fixed compute time. Optionally, the hold includes a fragmentation penalty. It reports acceptance, busy, and completion status back to the initiator.

---
 rtl/igcn_island_scheduler.sv | 170 +++++++++++++++++
 tb/tb_igcn_island_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/igcn_island_scheduler.sv
// Island submission responder: captures one request at a time, allocates one or two PEs,
// and holds each allocated PE for the configured compute time plus an optional penalty.
module igcn_island_scheduler #(
    parameter int NUM_PES                      = 4,
    parameter int C_MAX                        = 32,
    parameter int PE_COMPUTE_CYCLES            = 100,
    parameter int FRAGMENTATION_PENALTY_CYCLES = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_processing,
    input  logic [15:0] island_size,
    input  logic        strategy_is_enhanced,
    input  logic        island_needs_penalty,
    output logic        island_accepted,
    output logic        accelerator_busy,
    output logic        processing_done
);

    localparam int CW = $clog2(PE_COMPUTE_CYCLES + FRAGMENTATION_PENALTY_CYCLES + 1);
    localparam int FW = $clog2(NUM_PES + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT     = 2'd1,
        S_DISPATCH = 2'd2
    } state_e;

    function automatic logic [1:0] pes_needed(input logic [15:0] size, input logic enh);
        logic [1:0] n;
        if (size == 16'd0) begin
            n = 2'd0;
        end else if (!enh) begin
            n = 2'd1;
        end else if (size <= 16'(C_MAX)) begin
            n = 2'd1;
        end else begin
            n = 2'd2;
        end
        return n;
    endfunction

    state_e          state_q, state_d;
    logic            pend_valid_q, pend_valid_d;
    logic [15:0]     pend_size_q, pend_size_d;
    logic            pend_enh_q, pend_enh_d;
    logic            pend_pen_q, pend_pen_d;
    logic [CW-1:0]   cnt_q [NUM_PES];
    logic [CW-1:0]   cnt_d [NUM_PES];
    logic            any_acc_q, any_acc_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [1:0]      need_s;
    logic [CW-1:0]   occ_s;
    logic [FW-1:0]   free_cnt_s;
    logic            dispatch_s;
    logic            capture_s;
    logic            pe_active_s;
    logic [1:0]      taken_s;

    // Dispatch decision: a PE whose counter reaches zero at this edge may be reloaded.
    always_comb begin
        need_s     = pes_needed(pend_size_q, pend_enh_q);
        occ_s      = pend_pen_q ? CW'(PE_COMPUTE_CYCLES + FRAGMENTATION_PENALTY_CYCLES)
                                : CW'(PE_COMPUTE_CYCLES);
        free_cnt_s = '0;
        for (int i = 0; i < NUM_PES; i++) begin
            if (cnt_q[i] <= CW'(1)) begin
                free_cnt_s = free_cnt_s + FW'(1);
            end else begin
                free_cnt_s = free_cnt_s;
            end
        end
        dispatch_s = pend_valid_q && (free_cnt_s >= FW'(need_s));
        capture_s  = start_processing && (!pend_valid_q || dispatch_s);
    end

    // PE counters: load the lowest-index free PEs on dispatch, otherwise count down to zero.
    always_comb begin
        taken_s     = 2'd0;
        pe_active_s = 1'b0;
        for (int i = 0; i < NUM_PES; i++) begin
            if (dispatch_s && (cnt_q[i] <= CW'(1)) && (taken_s < need_s)) begin
                cnt_d[i] = occ_s;
                taken_s  = taken_s + 2'd1;
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end else begin
                cnt_d[i] = '0;
            end
            pe_active_s = pe_active_s | (cnt_d[i] != '0);
        end
    end

    // Pending slot, status flags and request FSM.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_size_d  = pend_size_q;
        pend_enh_d   = pend_enh_q;
        pend_pen_d   = pend_pen_q;
        state_d      = state_q;
        if (capture_s) begin
            pend_valid_d = 1'b1;
            pend_size_d  = island_size;
            pend_enh_d   = strategy_is_enhanced;
            pend_pen_d   = island_needs_penalty;
        end else if (dispatch_s) begin
            pend_valid_d = 1'b0;
        end else begin
            pend_valid_d = pend_valid_q;
        end
        any_acc_d = any_acc_q | dispatch_s;
        busy_d    = pend_valid_d | pe_active_s;
        done_d    = any_acc_d & ~busy_d;
        case (state_q)
            S_IDLE, S_DISPATCH: begin
                if (dispatch_s) begin
                    state_d = S_DISPATCH;
                end else if (pend_valid_q) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (dispatch_s) begin
                    state_d = S_DISPATCH;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pend_valid_q <= 1'b0;
            pend_size_q  <= 16'd0;
            pend_enh_q   <= 1'b0;
            pend_pen_q   <= 1'b0;
            any_acc_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < NUM_PES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_size_q  <= pend_size_d;
            pend_enh_q   <= pend_enh_d;
            pend_pen_q   <= pend_pen_d;
            any_acc_q    <= any_acc_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            for (int i = 0; i < NUM_PES; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign island_accepted  = (state_q == S_DISPATCH);
    assign accelerator_busy = busy_q;
    assign processing_done  = done_q;

endmodule

// File: tb/tb_igcn_island_scheduler.sv
// Self-checking bench for igcn_island_scheduler: directed scenarios plus random traffic,
// compared every cycle against a model that tracks each PE by the cycle it becomes free.
module tb_igcn_island_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_processing = 1'b0;
    logic [15:0] island_size = 16'd0;
    logic        strategy_is_enhanced = 1'b0;
    logic        island_needs_penalty = 1'b0;
    logic        island_accepted;
    logic        accelerator_busy;
    logic        processing_done;

    int checks = 0;
    int failures = 0;

    igcn_island_scheduler dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start_processing     (start_processing),
        .island_size          (island_size),
        .strategy_is_enhanced (strategy_is_enhanced),
        .island_needs_penalty (island_needs_penalty),
        .island_accepted      (island_accepted),
        .accelerator_busy     (accelerator_busy),
        .processing_done      (processing_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    // Reference model: edge counter, cycle at which each PE is free again, 1-deep pending slot.
    longint cyc = 0;
    longint free_at [4];
    bit     p_v, p_enh, p_pen;
    int     p_size;
    bit     m_acc, m_busy, m_done, m_any;
    int     mm_cnt = 0;
    longint mm_first = 0;
    longint acc_cyc = 0;

    task automatic model_edge(input bit rst, input bit s, input int sz, input bit e, input bit p);
        int need, avail, got;
        cyc++;
        if (!rst) begin
            foreach (free_at[i]) free_at[i] = 0;
            p_v = 0; m_acc = 0; m_busy = 0; m_done = 0; m_any = 0;
            return;
        end
        m_acc = 0;
        if (p_v) begin
            need  = (p_size == 0) ? 0 : (!p_enh ? 1 : (p_size <= 32 ? 1 : 2));
            avail = 0;
            foreach (free_at[i]) if (free_at[i] <= cyc) avail++;
            if (avail >= need) begin
                got = 0;
                foreach (free_at[i]) begin
                    if (got < need && free_at[i] <= cyc) begin
                        free_at[i] = cyc + (p_pen ? 150 : 100);
                        got++;
                    end
                end
                p_v = 0; m_acc = 1; m_any = 1;
            end
        end
        if (s && !p_v) begin
            p_v = 1; p_size = sz; p_enh = e; p_pen = p;
        end
        m_busy = p_v;
        foreach (free_at[i]) if (free_at[i] > cyc) m_busy = 1;
        m_done = m_any && !m_busy;
    endtask

    // One clock edge: drive inputs, advance the model, then sample the DUT 1 time unit later.
    task automatic tick(input bit s, input logic [15:0] sz, input bit e, input bit p);
        start_processing     = s;
        island_size          = sz;
        strategy_is_enhanced = e;
        island_needs_penalty = p;
        @(posedge clk);
        model_edge(rst_n, s, int'(sz), e, p);
        #1;
        start_processing = 1'b0;
        if (m_acc) acc_cyc = cyc;
        if ({island_accepted, accelerator_busy, processing_done} !== {m_acc, m_busy, m_done}) begin
            if (mm_cnt == 0) mm_first = cyc;
            mm_cnt++;
        end
    endtask

    // Submit at the next edge and wait (bounded) for the accept; lat = edges after sampling, -1 on timeout.
    task automatic submit_wait(input logic [15:0] sz, input bit e, input bit p, output int lat);
        tick(1'b1, sz, e, p);
        lat = 0;
        while (!island_accepted && lat < 400) begin
            tick(1'b0, 16'd0, 1'b0, 1'b0);
            lat++;
        end
        if (!island_accepted) lat = -1;
    endtask

    task automatic test_reset;
        mm_cnt = 0;
        rst_n = 1'b0;
        tick(1'b0, 16'd0, 1'b0, 1'b0);
        tick(1'b1, 16'd5, 1'b0, 1'b0);
        checks++;
        if ({island_accepted, accelerator_busy, processing_done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_state got=%b expected=000", {island_accepted, accelerator_busy, processing_done});
        end
        rst_n = 1'b1;
        tick(1'b1, 16'd16, 1'b0, 1'b0);
        checks++;
        if ({island_accepted, accelerator_busy, processing_done} !== 3'b010) begin
            failures++;
            $display("FAIL first_capture got=%b expected=010", {island_accepted, accelerator_busy, processing_done});
        end
        tick(1'b0, 16'd0, 1'b0, 1'b0);
        checks++;
        if ({island_accepted, accelerator_busy, processing_done} !== 3'b110) begin
            failures++;
            $display("FAIL first_accept got=%b expected=110", {island_accepted, accelerator_busy, processing_done});
        end
        repeat (99) tick(1'b0, 16'd0, 1'b0, 1'b0);
        checks++;
        if ({island_accepted, accelerator_busy, processing_done} !== 3'b010) begin
            failures++;
            $display("FAIL busy_at_99 got=%b expected=010", {island_accepted, accelerator_busy, processing_done});
        end
        tick(1'b0, 16'd0, 1'b0, 1'b0);
        checks++;
        if ({island_accepted, accelerator_busy, processing_done} !== 3'b001) begin
            failures++;
            $display("FAIL done_at_100 got=%b expected=001", {island_accepted, accelerator_busy, processing_done});
        end
        checks++;
        if (mm_cnt != 0) begin
            failures++;
            $display("FAIL reset_model mismatches=%0d first_cycle=%0d expected=0", mm_cnt, mm_first);
        end
    endtask

    task automatic test_back_to_back;
        int     lat [5];
        longint t [5];
        mm_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            submit_wait(16'd32, 1'b0, 1'b1, lat[k]);
            t[k] = acc_cyc;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (lat[k] != 1) begin
                failures++;
                $display("FAIL b2b_latency idx=%0d got=%0d expected=1", k, lat[k]);
            end
        end
        checks++;
        if (lat[4] < 0 || t[4] - t[0] != 150) begin
            failures++;
            $display("FAIL b2b_fifth_wait got=%0d expected=150", t[4] - t[0]);
        end
        repeat (150) tick(1'b0, 16'd0, 1'b0, 1'b0);
        checks++;
        if ({accelerator_busy, processing_done} !== 2'b01) begin
            failures++;
            $display("FAIL b2b_done got=%b expected=01", {accelerator_busy, processing_done});
        end
        checks++;
        if (mm_cnt != 0) begin
            failures++;
            $display("FAIL b2b_model mismatches=%0d first_cycle=%0d expected=0", mm_cnt, mm_first);
        end
    endtask

    task automatic test_enhanced;
        int     l0, l1, l2, l3, lx;
        longint t0, t2;
        mm_cnt = 0;
        submit_wait(16'd42, 1'b1, 1'b0, l0);
        t0 = acc_cyc;
        submit_wait(16'd60, 1'b1, 1'b0, l1);
        submit_wait(16'd50, 1'b1, 1'b0, l2);
        t2 = acc_cyc;
        checks++;
        if (l0 != 1 || l1 != 1) begin
            failures++;
            $display("FAIL enh_pair_latency got=%0d,%0d expected=1,1", l0, l1);
        end
        checks++;
        if (l2 < 0 || t2 - t0 != 100) begin
            failures++;
            $display("FAIL enh_third_wait got=%0d expected=100", t2 - t0);
        end
        repeat (105) tick(1'b0, 16'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) submit_wait(16'd5, 1'b0, 1'b0, lx);
        submit_wait(16'd16, 1'b1, 1'b1, l3);
        checks++;
        if (l3 != 1) begin
            failures++;
            $display("FAIL enh_single_free got=%0d expected=1", l3);
        end
        repeat (160) tick(1'b0, 16'd0, 1'b0, 1'b0);
        tick(1'b1, 16'd0, 1'b1, 1'b0);
        tick(1'b0, 16'd0, 1'b0, 1'b0);
        checks++;
        if ({island_accepted, accelerator_busy, processing_done} !== 3'b101) begin
            failures++;
            $display("FAIL size_zero got=%b expected=101", {island_accepted, accelerator_busy, processing_done});
        end
        tick(1'b0, 16'd0, 1'b0, 1'b0);
        checks++;
        if (mm_cnt != 0) begin
            failures++;
            $display("FAIL enh_model mismatches=%0d first_cycle=%0d expected=0", mm_cnt, mm_first);
        end
    endtask

    task automatic test_reset_midop;
        int lx, n_acc;
        mm_cnt = 0;
        for (int k = 0; k < 3; k++) submit_wait(16'd8, 1'b0, 1'b0, lx);
        tick(1'b1, 16'd60, 1'b1, 1'b0);
        tick(1'b0, 16'd0, 1'b0, 1'b0);
        checks++;
        if ({island_accepted, accelerator_busy} !== 2'b01) begin
            failures++;
            $display("FAIL midop_pending got=%b expected=01", {island_accepted, accelerator_busy});
        end
        rst_n = 1'b0;
        tick(1'b0, 16'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        checks++;
        if ({island_accepted, accelerator_busy, processing_done} !== 3'b000) begin
            failures++;
            $display("FAIL midop_reset got=%b expected=000", {island_accepted, accelerator_busy, processing_done});
        end
        n_acc = 0;
        repeat (200) begin
            tick(1'b0, 16'd0, 1'b0, 1'b0);
            if (island_accepted) n_acc++;
        end
        checks++;
        if (n_acc != 0) begin
            failures++;
            $display("FAIL midop_no_accept got=%0d expected=0", n_acc);
        end
        submit_wait(16'd16, 1'b0, 1'b0, lx);
        repeat (100) tick(1'b0, 16'd0, 1'b0, 1'b0);
        checks++;
        if (lx != 1 || {accelerator_busy, processing_done} !== 2'b01) begin
            failures++;
            $display("FAIL midop_rerun got=lat%0d,%b expected=lat1,01", lx, {accelerator_busy, processing_done});
        end
        checks++;
        if (mm_cnt != 0) begin
            failures++;
            $display("FAIL midop_model mismatches=%0d first_cycle=%0d expected=0", mm_cnt, mm_first);
        end
    endtask

    task automatic test_ignored_start;
        int     lx, n_acc;
        longint t0;
        mm_cnt = 0;
        submit_wait(16'd8, 1'b0, 1'b0, lx);
        t0 = acc_cyc;
        for (int k = 0; k < 3; k++) submit_wait(16'd8, 1'b0, 1'b0, lx);
        tick(1'b1, 16'd8, 1'b0, 1'b0);
        n_acc = 0;
        for (int n = 0; n < 120; n++) begin
            tick((n < 80) && (n % 10 == 3), 16'd20, 1'b0, 1'b1);
            if (island_accepted) n_acc++;
        end
        checks++;
        if (n_acc != 1 || acc_cyc - t0 != 100) begin
            failures++;
            $display("FAIL ignored_start got=%0d accepts at +%0d expected=1 at +100", n_acc, acc_cyc - t0);
        end
        repeat (110) tick(1'b0, 16'd0, 1'b0, 1'b0);
        checks++;
        if (mm_cnt != 0) begin
            failures++;
            $display("FAIL ignored_model mismatches=%0d first_cycle=%0d expected=0", mm_cnt, mm_first);
        end
    endtask

    task automatic test_random;
        logic [15:0] sz;
        int          kind;
        mm_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            kind = int'($urandom_range(0, 3));
            case (kind)
                0:       sz = 16'd0;
                1:       sz = 16'($urandom_range(1, 32));
                2:       sz = 16'($urandom_range(33, 64));
                default: sz = 16'($urandom_range(65, 300));
            endcase
            rst_n = ($urandom_range(0, 399) != 0);
            tick($urandom_range(0, 3) == 0, sz, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            rst_n = 1'b1;
        end
        checks++;
        if (mm_cnt != 0) begin
            failures++;
            $display("FAIL random_model mismatches=%0d first_cycle=%0d expected=0", mm_cnt, mm_first);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_enhanced();
        test_reset_midop();
        test_ignored_start();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
